// File: rtl/pucch_f0_cs_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pucch_f0_cs_detector                                       |
// | Description : PUCCH format-0 cyclic-shift detector. Buffers 12 derotated |
// |               subcarrier samples, correlates them against 2 or 4 cyclic  |
// |               shift candidates and reports the HARQ-ACK bits of the      |
// |               candidate with the largest L1 correlation metric.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pucch_f0_cs_detector #(
   parameter int DW = 16,
   parameter int AW = DW + 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [3:0]           i_cs_base,
   input  logic [1:0]           i_nbits,
   input  logic                 i_valid,
   input  logic signed [DW-1:0] i_re,
   input  logic signed [DW-1:0] i_im,
   output logic                 o_ready,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [1:0]           o_harq,
   output logic [3:0]           o_cs_det,
   output logic [AW:0]          o_metric
);

   // Full-precision product width (sample x Q2.14 twiddle)
   localparam int PW = DW + 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CORR = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [3:0]            r_cs_base;
   logic                  r_two;        // 1: nbits=2 (4 candidates), 0: nbits=1
   logic [3:0]            r_k;          // sample index in LOAD, MAC index (12 = compare) in CORR
   logic [1:0]            r_cand;
   logic [3:0]            r_ph;         // running (cs*k) mod 12
   logic signed [AW-1:0]  r_acc_re;
   logic signed [AW-1:0]  r_acc_im;
   logic [AW:0]           r_best_metric;
   logic [1:0]            r_best_cand;
   logic [3:0]            r_best_cs;
   logic                  r_done;
   logic [1:0]            r_harq;
   logic [3:0]            r_cs_det;
   logic [AW:0]           r_metric;

   logic signed [DW-1:0]  r_buf_re [0:11];
   logic signed [DW-1:0]  r_buf_im [0:11];

   logic                  w_start_ok;
   logic                  w_last_cand;
   logic [3:0]            w_cs_in_red;
   logic [3:0]            w_mcs;
   logic [4:0]            w_cs_sum;
   logic [3:0]            w_cs;
   logic [4:0]            w_ph_sum;
   logic [3:0]            w_ph_nxt;
   logic [3:0]            w_kidx;
   logic signed [DW-1:0]  w_y_re;
   logic signed [DW-1:0]  w_y_im;
   logic signed [15:0]    w_cos;
   logic signed [15:0]    w_sin;
   logic signed [PW-1:0]  w_ac;
   logic signed [PW-1:0]  w_bs;
   logic signed [PW-1:0]  w_bc;
   logic signed [PW-1:0]  w_as;
   logic signed [PW:0]    w_re_full;
   logic signed [PW:0]    w_im_full;
   logic signed [AW-1:0]  w_re_inc;
   logic signed [AW-1:0]  w_im_inc;
   logic [AW:0]           w_abs_re;
   logic [AW:0]           w_abs_im;
   logic [AW:0]           w_metric;
   logic [1:0]            w_harq_best;

   // A start pulse landing in the result cycle is held off by one cycle
   assign w_start_ok  = (r_state == S_IDLE) && i_start && !r_done;
   assign w_last_cand = r_two ? (r_cand == 2'd3) : (r_cand == 2'd1);
   assign w_cs_in_red = (i_cs_base >= 4'd12) ? (i_cs_base - 4'd12) : i_cs_base;

   // Candidate offset: 3*cand for 4 candidates, 6*cand for 2 candidates
   assign w_mcs    = r_two ? ({1'b0, r_cand, 1'b0} + {2'b00, r_cand})
                           : (r_cand[0] ? 4'd6 : 4'd0);
   assign w_cs_sum = {1'b0, r_cs_base} + {1'b0, w_mcs};
   assign w_cs     = (w_cs_sum >= 5'd12) ? 4'(w_cs_sum - 5'd12) : w_cs_sum[3:0];

   assign w_ph_sum = {1'b0, r_ph} + {1'b0, w_cs};
   assign w_ph_nxt = (w_ph_sum >= 5'd12) ? 4'(w_ph_sum - 5'd12) : w_ph_sum[3:0];

   assign w_kidx = (r_k < 4'd12) ? r_k : 4'd0;
   assign w_y_re = r_buf_re[w_kidx];
   assign w_y_im = r_buf_im[w_kidx];

   // Twiddle ROM: Q2.14 cos/sin of 30-degree steps
   always_comb begin
      w_cos = 16'sd0;
      w_sin = 16'sd0;
      case (r_ph)
         4'd0:  begin w_cos =  16'sd16384; w_sin =  16'sd0;     end
         4'd1:  begin w_cos =  16'sd14189; w_sin =  16'sd8192;  end
         4'd2:  begin w_cos =  16'sd8192;  w_sin =  16'sd14189; end
         4'd3:  begin w_cos =  16'sd0;     w_sin =  16'sd16384; end
         4'd4:  begin w_cos = -16'sd8192;  w_sin =  16'sd14189; end
         4'd5:  begin w_cos = -16'sd14189; w_sin =  16'sd8192;  end
         4'd6:  begin w_cos = -16'sd16384; w_sin =  16'sd0;     end
         4'd7:  begin w_cos = -16'sd14189; w_sin = -16'sd8192;  end
         4'd8:  begin w_cos = -16'sd8192;  w_sin = -16'sd14189; end
         4'd9:  begin w_cos =  16'sd0;     w_sin = -16'sd16384; end
         4'd10: begin w_cos =  16'sd8192;  w_sin = -16'sd14189; end
         4'd11: begin w_cos =  16'sd14189; w_sin = -16'sd8192;  end
         default: begin w_cos = 16'sd0;    w_sin = 16'sd0;      end
      endcase
   end

   // y * exp(-j*theta) = (a*c + b*s) + j(b*c - a*s), each part scaled down by 2^14
   assign w_ac      = PW'(w_y_re) * PW'(w_cos);
   assign w_bs      = PW'(w_y_im) * PW'(w_sin);
   assign w_bc      = PW'(w_y_im) * PW'(w_cos);
   assign w_as      = PW'(w_y_re) * PW'(w_sin);
   assign w_re_full = (PW+1)'(w_ac) + (PW+1)'(w_bs);
   assign w_im_full = (PW+1)'(w_bc) - (PW+1)'(w_as);
   assign w_re_inc  = AW'(w_re_full >>> 14);
   assign w_im_inc  = AW'(w_im_full >>> 14);

   // L1 magnitude, one bit wider so the most negative accumulator value is exact
   assign w_abs_re = r_acc_re[AW-1] ? ((AW+1)'(0) - (AW+1)'(r_acc_re)) : (AW+1)'(r_acc_re);
   assign w_abs_im = r_acc_im[AW-1] ? ((AW+1)'(0) - (AW+1)'(r_acc_im)) : (AW+1)'(r_acc_im);
   assign w_metric = w_abs_re + w_abs_im;

   // Gray-style HARQ mapping for 2 bits: cand 0,1,2,3 -> 00,01,11,10
   assign w_harq_best = r_two ? {r_best_cand[1], r_best_cand[1] ^ r_best_cand[0]}
                              : {1'b0, r_best_cand[0]};

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start_ok) w_state_nxt = S_LOAD;
         S_LOAD: if (i_valid && (r_k == 4'd11)) w_state_nxt = S_CORR;
         S_CORR: if ((r_k == 4'd12) && w_last_cand) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Sample buffer capture (data only, no reset needed)
   always_ff @(posedge i_clk) begin
      if ((r_state == S_LOAD) && i_valid) begin
         r_buf_re[r_k] <= i_re;
         r_buf_im[r_k] <= i_im;
      end
   end

   // Control counters, correlation datapath and result registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cs_base     <= 4'd0;
         r_two         <= 1'b0;
         r_k           <= 4'd0;
         r_cand        <= 2'd0;
         r_ph          <= 4'd0;
         r_acc_re      <= '0;
         r_acc_im      <= '0;
         r_best_metric <= '0;
         r_best_cand   <= 2'd0;
         r_best_cs     <= 4'd0;
         r_done        <= 1'b0;
         r_harq        <= 2'd0;
         r_cs_det      <= 4'd0;
         r_metric      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_cs_base <= w_cs_in_red;
                  r_two     <= (i_nbits >= 2'd2);
                  r_k       <= 4'd0;
                  r_cand    <= 2'd0;
                  r_ph      <= 4'd0;
                  r_acc_re  <= '0;
                  r_acc_im  <= '0;
               end
            end
            S_LOAD: begin
               if (i_valid) begin
                  r_k <= (r_k == 4'd11) ? 4'd0 : (r_k + 4'd1);
               end
            end
            S_CORR: begin
               if (r_k == 4'd12) begin
                  // Compare cycle: strictly-greater keeps the lower candidate on ties
                  if ((r_cand == 2'd0) || (w_metric > r_best_metric)) begin
                     r_best_metric <= w_metric;
                     r_best_cand   <= r_cand;
                     r_best_cs     <= w_cs;
                  end
                  r_acc_re <= '0;
                  r_acc_im <= '0;
                  r_k      <= 4'd0;
                  r_ph     <= 4'd0;
                  r_cand   <= r_cand + 2'd1;
               end else begin
                  r_acc_re <= r_acc_re + w_re_inc;
                  r_acc_im <= r_acc_im + w_im_inc;
                  r_k      <= r_k + 4'd1;
                  r_ph     <= w_ph_nxt;
               end
            end
            S_DONE: begin
               r_done   <= 1'b1;
               r_harq   <= w_harq_best;
               r_cs_det <= r_best_cs;
               r_metric <= r_best_metric;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready  = (r_state == S_LOAD);
   assign o_busy   = (r_state != S_IDLE);
   assign o_done   = r_done;
   assign o_harq   = r_harq;
   assign o_cs_det = r_cs_det;
   assign o_metric = r_metric;

endmodule
`default_nettype wire

// File: tb/tb_pucch_f0_cs_detector.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_pucch_f0_cs_detector                                    |
// | Description : Self-checking bench for the PUCCH F0 cyclic-shift detector |
// |               with a trigonometric reference model.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pucch_f0_cs_detector;

   localparam int  DW = 16;
   localparam int  AW = DW + 4;
   localparam real PI = 3.14159265358979;

   logic                 i_clk = 1'b0;
   logic                 i_rst_n = 1'b0;
   logic                 i_start = 1'b0;
   logic [3:0]           i_cs_base = 4'd0;
   logic [1:0]           i_nbits = 2'd0;
   logic                 i_valid = 1'b0;
   logic signed [DW-1:0] i_re = '0;
   logic signed [DW-1:0] i_im = '0;
   logic                 o_ready;
   logic                 o_busy;
   logic                 o_done;
   logic [1:0]           o_harq;
   logic [3:0]           o_cs_det;
   logic [AW:0]          o_metric;

   int n_vec = 0;
   int n_err = 0;

   int s_re [12];
   int s_im [12];

   int          obs_lat;
   logic [1:0]  obs_harq;
   logic [3:0]  obs_cs;
   logic [AW:0] obs_met;
   logic        obs_busy;
   logic        obs_done2;
   logic        obs_acc;

   int     exp_cs;
   int     exp_harq;
   longint exp_met;
   int     exp_lat;

   pucch_f0_cs_detector #(.DW(DW), .AW(AW)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (i_start),
      .i_cs_base (i_cs_base),
      .i_nbits   (i_nbits),
      .i_valid   (i_valid),
      .i_re      (i_re),
      .i_im      (i_im),
      .o_ready   (o_ready),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_harq    (o_harq),
      .o_cs_det  (o_cs_det),
      .o_metric  (o_metric)
   );

   // Free-running clock
   always #5 i_clk = ~i_clk;

   function automatic int rnd(input real x);
      return $rtoi($floor(x + 0.5));
   endfunction

   function automatic longint wrap_acc(input longint v);
      longint m = longint'(1) << AW;
      longint r = v % m;
      if (r >= m / 2) r -= m;
      else if (r < -(m / 2)) r += m;
      return r;
   endfunction

   function automatic longint labs(input longint v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference: correlate against exp(-j*2*pi*cs*k/12) for every candidate shift
   task automatic model(input int base, input int nb);
      int     b    = base % 12;
      bit     two  = (nb >= 2);
      int     nc   = two ? 4 : 2;
      int     step = two ? 3 : 6;
      longint best = -1;
      int     best_mcs = 0;
      for (int c = 0; c < nc; c++) begin
         int     mcs = c * step;
         int     cs  = (b + mcs) % 12;
         longint cre = 0;
         longint cim = 0;
         longint met;
         for (int k = 0; k < 12; k++) begin
            real    ang = 2.0 * PI * real'((cs * k) % 12) / 12.0;
            longint tc  = longint'(rnd(16384.0 * $cos(ang)));
            longint ts  = longint'(rnd(16384.0 * $sin(ang)));
            longint a   = longint'(s_re[k]);
            longint bb  = longint'(s_im[k]);
            cre = wrap_acc(cre + ((a * tc + bb * ts) >>> 14));
            cim = wrap_acc(cim + ((bb * tc - a * ts) >>> 14));
         end
         met = labs(cre) + labs(cim);
         if (c == 0 || met > best) begin
            best     = met;
            best_mcs = mcs;
            exp_cs   = cs;
         end
      end
      exp_met = best;
      case (best_mcs)
         0:       exp_harq = 0;
         3:       exp_harq = 1;
         6:       exp_harq = two ? 3 : 1;
         default: exp_harq = 2;
      endcase
      exp_lat = 13 * nc + 1;
   endtask

   task automatic set_tone(input int sh, input int amp, input int noise);
      for (int k = 0; k < 12; k++) begin
         real ang = 2.0 * PI * real'(sh * k) / 12.0;
         int  nr  = (noise > 0) ? int'($urandom_range(0, 2 * noise)) - noise : 0;
         int  ni  = (noise > 0) ? int'($urandom_range(0, 2 * noise)) - noise : 0;
         s_re[k] = rnd(real'(amp) * $cos(ang)) + nr;
         s_im[k] = rnd(real'(amp) * $sin(ang)) + ni;
      end
   endtask

   // Stimulus only: start, feed 12 samples, wait for the result strobe
   task automatic drive_run(input int base, input int nb, input bit gaps, input bit start_mid);
      int k = 0;
      int guard = 0;
      bit rdy;
      bit tog = 1'b0;
      i_cs_base = 4'(base);
      i_nbits   = 2'(nb);
      i_start   = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      obs_acc = o_ready & o_busy;
      while (k < 12 && guard < 200) begin
         if (gaps && tog) begin
            i_valid = 1'b0;
         end else begin
            i_valid = 1'b1;
            i_re    = DW'(s_re[k]);
            i_im    = DW'(s_im[k]);
         end
         tog = !tog;
         rdy = o_ready;
         @(posedge i_clk); #1;
         if (rdy && i_valid) k++;
         guard++;
      end
      i_valid = 1'b0;
      obs_lat = -1;
      obs_harq = 'x; obs_cs = 'x; obs_met = 'x; obs_busy = 'x;
      if (k == 12) begin
         for (int n = 1; n <= 300; n++) begin
            if (start_mid && n == 5) i_start = 1'b1;
            @(posedge i_clk); #1;
            i_start = 1'b0;
            if (o_done === 1'b1) begin
               obs_lat  = n;
               obs_harq = o_harq;
               obs_cs   = o_cs_det;
               obs_met  = o_metric;
               obs_busy = o_busy;
               break;
            end
         end
      end
      @(posedge i_clk); #1;
      obs_done2 = o_done;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      n_vec++; if ({o_ready, o_busy, o_done} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl: got %b want 000", {o_ready, o_busy, o_done}); end
      n_vec++; if ({o_harq, o_cs_det} !== 6'd0) begin n_err++; $display("FAIL reset_result: got harq=%0d cs=%0d want 0", o_harq, o_cs_det); end
      n_vec++; if (o_metric !== '0) begin n_err++; $display("FAIL reset_metric: got %0d want 0", o_metric); end
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      n_vec++; if ({o_ready, o_busy, o_done} !== 3'b000) begin n_err++; $display("FAIL idle_ctrl: got %b want 000", {o_ready, o_busy, o_done}); end
   endtask

   task automatic test_dc();
      for (int k = 0; k < 12; k++) begin s_re[k] = 8192; s_im[k] = 0; end
      drive_run(0, 1, 1'b0, 1'b0);
      n_vec++; if (obs_acc !== 1'b1) begin n_err++; $display("FAIL dc_accept: got %b want 1", obs_acc); end
      n_vec++; if (obs_lat != 27) begin n_err++; $display("FAIL dc_latency: got %0d want 27", obs_lat); end
      n_vec++; if (obs_cs !== 4'd0) begin n_err++; $display("FAIL dc_cs: got %0d want 0", obs_cs); end
      n_vec++; if (obs_harq !== 2'd0) begin n_err++; $display("FAIL dc_harq: got %0d want 0", obs_harq); end
      n_vec++; if (obs_met !== 21'd98304) begin n_err++; $display("FAIL dc_metric: got %0d want 98304", obs_met); end
      n_vec++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL dc_busy_at_done: got %b want 0", obs_busy); end
      n_vec++; if (obs_done2 !== 1'b0) begin n_err++; $display("FAIL dc_done_width: got %b want 0", obs_done2); end
   endtask

   task automatic test_tone9();
      set_tone(9, 8192, 0);
      model(0, 2);
      drive_run(0, 2, 1'b0, 1'b0);
      n_vec++; if (obs_lat != 53) begin n_err++; $display("FAIL tone9_latency: got %0d want 53", obs_lat); end
      n_vec++; if (obs_cs !== 4'd9) begin n_err++; $display("FAIL tone9_cs: got %0d want 9", obs_cs); end
      n_vec++; if (obs_harq !== 2'b10) begin n_err++; $display("FAIL tone9_harq: got %b want 10", obs_harq); end
      n_vec++; if (longint'(obs_met) != exp_met) begin n_err++; $display("FAIL tone9_metric: got %0d want %0d", obs_met, exp_met); end
   endtask

   task automatic test_shift8();
      set_tone(8, 8192, 0);
      drive_run(5, 2, 1'b0, 1'b0);
      n_vec++; if (obs_cs !== 4'd8) begin n_err++; $display("FAIL shift8_cs: got %0d want 8", obs_cs); end
      n_vec++; if (obs_harq !== 2'b01) begin n_err++; $display("FAIL shift8_harq: got %b want 01", obs_harq); end
   endtask

   task automatic test_zero_tie();
      for (int k = 0; k < 12; k++) begin s_re[k] = 0; s_im[k] = 0; end
      drive_run(7, 2, 1'b0, 1'b0);
      n_vec++; if (obs_cs !== 4'd7) begin n_err++; $display("FAIL tie_cs: got %0d want 7", obs_cs); end
      n_vec++; if (obs_harq !== 2'b00) begin n_err++; $display("FAIL tie_harq: got %b want 00", obs_harq); end
      n_vec++; if (obs_met !== '0) begin n_err++; $display("FAIL tie_metric: got %0d want 0", obs_met); end
   endtask

   task automatic test_gaps_and_start();
      int base = int'($urandom_range(0, 15));
      set_tone(int'($urandom_range(0, 11)), 6000, 800);
      model(base, 2);
      drive_run(base, 2, 1'b1, 1'b1);
      n_vec++; if (obs_lat != 53) begin n_err++; $display("FAIL gaps_latency: got %0d want 53", obs_lat); end
      n_vec++; if (int'(obs_cs) != exp_cs) begin n_err++; $display("FAIL gaps_cs: got %0d want %0d", obs_cs, exp_cs); end
      n_vec++; if (int'(obs_harq) != exp_harq) begin n_err++; $display("FAIL gaps_harq: got %0d want %0d", obs_harq, exp_harq); end
      n_vec++; if (longint'(obs_met) != exp_met) begin n_err++; $display("FAIL gaps_metric: got %0d want %0d", obs_met, exp_met); end
      n_vec++; if (obs_done2 !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL gaps_stray_start: got done=%b busy=%b want 0 0", obs_done2, o_busy); end
   endtask

   task automatic test_back_to_back();
      set_tone(2, 5000, 500);
      model(1, 1);
      drive_run(1, 1, 1'b0, 1'b0);
      n_vec++; if (int'(obs_cs) != exp_cs) begin n_err++; $display("FAIL b2b_first_cs: got %0d want %0d", obs_cs, exp_cs); end
      set_tone(10, 7000, 500);
      model(4, 2);
      drive_run(4, 2, 1'b0, 1'b0);
      n_vec++; if (obs_acc !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got %b want 1", obs_acc); end
      n_vec++; if (obs_lat != exp_lat) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", obs_lat, exp_lat); end
      n_vec++; if (int'(obs_cs) != exp_cs) begin n_err++; $display("FAIL b2b_cs: got %0d want %0d", obs_cs, exp_cs); end
      n_vec++; if (longint'(obs_met) != exp_met) begin n_err++; $display("FAIL b2b_metric: got %0d want %0d", obs_met, exp_met); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 24; r++) begin
         int base = int'($urandom_range(0, 15));
         int nb   = int'($urandom_range(0, 3));
         if (r % 3 == 2) begin
            for (int k = 0; k < 12; k++) begin
               s_re[k] = int'($urandom_range(0, 65535)) - 32768;
               s_im[k] = int'($urandom_range(0, 65535)) - 32768;
            end
         end else begin
            set_tone(int'($urandom_range(0, 11)), int'($urandom_range(500, 9000)), 1500);
         end
         model(base, nb);
         drive_run(base, nb, r[0], 1'b0);
         n_vec++; if (obs_lat != exp_lat) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", r, obs_lat, exp_lat); end
         n_vec++; if (int'(obs_cs) != exp_cs) begin n_err++; $display("FAIL rand%0d_cs: got %0d want %0d", r, obs_cs, exp_cs); end
         n_vec++; if (int'(obs_harq) != exp_harq) begin n_err++; $display("FAIL rand%0d_harq: got %0d want %0d", r, obs_harq, exp_harq); end
         n_vec++; if (longint'(obs_met) != exp_met) begin n_err++; $display("FAIL rand%0d_metric: got %0d want %0d", r, obs_met, exp_met); end
      end
   endtask

   task automatic test_reset_mid_corr();
      bit seen = 1'b0;
      set_tone(4, 6000, 300);
      i_cs_base = 4'd3; i_nbits = 2'd2; i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         i_valid = 1'b1; i_re = DW'(s_re[k]); i_im = DW'(s_im[k]);
         @(posedge i_clk); #1;
      end
      i_valid = 1'b0;
      repeat (10) @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      #1;
      n_vec++; if ({o_ready, o_busy, o_done} !== 3'b000) begin n_err++; $display("FAIL midrst_ctrl: got %b want 000", {o_ready, o_busy, o_done}); end
      n_vec++; if ({o_harq, o_cs_det} !== 6'd0) begin n_err++; $display("FAIL midrst_result: got harq=%0d cs=%0d want 0", o_harq, o_cs_det); end
      n_vec++; if (o_metric !== '0) begin n_err++; $display("FAIL midrst_metric: got %0d want 0", o_metric); end
      repeat (3) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      repeat (80) begin
         @(posedge i_clk); #1;
         if (o_done !== 1'b0) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_done: got %b want 0", seen); end
      for (int k = 0; k < 12; k++) begin s_re[k] = 8192; s_im[k] = 0; end
      drive_run(0, 1, 1'b0, 1'b0);
      n_vec++; if (obs_lat != 27) begin n_err++; $display("FAIL midrst_rerun_latency: got %0d want 27", obs_lat); end
      n_vec++; if (obs_cs !== 4'd0 || obs_harq !== 2'd0) begin n_err++; $display("FAIL midrst_rerun_result: got cs=%0d harq=%0d want 0 0", obs_cs, obs_harq); end
      n_vec++; if (obs_met !== 21'd98304) begin n_err++; $display("FAIL midrst_rerun_metric: got %0d want 98304", obs_met); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_dc();
      test_tone9();
      test_shift8();
      test_zero_tie();
      test_gaps_and_start();
      test_back_to_back();
      test_random();
      test_reset_mid_corr();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
